motor_pwm_timebase: RTL and testbench

- Upstream timebase for the three-phase motor PWM chain.
- Runs the shared up-counter and sync pulse that every phase stage consumes.
- Holds double-buffered (shadow/active) period, deadband and per-phase duty.
- Shadow values reach the phase stages only at the counter wrap to 0, so a phase always latches one consistent set at counter == 0.

---
 rtl/motor_pwm_pkg.sv | 8 +
 rtl/motor_pwm_shadow.sv | 68 ++++++
 rtl/motor_pwm_timebase.sv | 85 ++++++++
 tb/tb_motor_pwm_timebase.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: state encoding and default sizes shared by the motor PWM timebase files
package motor_pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int SIZE_DEF = 16;
  localparam int PHASES_DEF = 3;
  localparam int RST_PERIOD_DEF = 1000;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/motor_pwm_shadow.sv
// motor_pwm_shadow: clamps requested period/deadband/duties into a shadow set and copies it to the active set on apply
module motor_pwm_shadow
  import motor_pwm_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int PHASES = PHASES_DEF,
  parameter int RST_PERIOD = RST_PERIOD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   apply,
  input  logic [SIZE-1:0]        period,
  input  logic [SIZE-1:0]        deadband,
  input  logic [PHASES*SIZE-1:0] duty,
  output logic [SIZE-1:0]        act_period,
  output logic [SIZE-1:0]        act_deadband,
  output logic [PHASES*SIZE-1:0] act_duty,
  output logic                   pending,
  output logic                   applied
);
  logic [SIZE-1:0] per_c, db_c, dmax;
  logic [PHASES*SIZE-1:0] duty_c;
  logic [SIZE-1:0] sh_per_q, sh_per_d, sh_db_q, sh_db_d, act_per_q, act_per_d, act_db_q, act_db_d;
  logic [PHASES*SIZE-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic pend_q, pend_d;
  always_comb begin
    per_c = period < SIZE'(MIN_PERIOD) ? SIZE'(MIN_PERIOD) : period;
    dmax = '0;
    duty_c = '0;
    for (int k = 0; k < PHASES; k++) begin
      duty_c[k*SIZE +: SIZE] = duty[k*SIZE +: SIZE] > per_c ? per_c : duty[k*SIZE +: SIZE];
      dmax = duty_c[k*SIZE +: SIZE] > dmax ? duty_c[k*SIZE +: SIZE] : dmax;
    end
    db_c = {1'b0, dmax} + {1'b0, deadband} > {1'b0, per_c} ? per_c - dmax : deadband;
    applied = apply && pend_q && !load;
    sh_per_d = load ? per_c : sh_per_q;
    sh_db_d = load ? db_c : sh_db_q;
    sh_duty_d = load ? duty_c : sh_duty_q;
    act_per_d = applied ? sh_per_q : act_per_q;
    act_db_d = applied ? sh_db_q : act_db_q;
    act_duty_d = applied ? sh_duty_q : act_duty_q;
    pend_d = load || (pend_q && !apply);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_per_q <= SIZE'(RST_PERIOD);
      sh_db_q <= '0;
      sh_duty_q <= '0;
      act_per_q <= SIZE'(RST_PERIOD);
      act_db_q <= '0;
      act_duty_q <= '0;
      pend_q <= 1'b0;
    end else begin
      sh_per_q <= sh_per_d;
      sh_db_q <= sh_db_d;
      sh_duty_q <= sh_duty_d;
      act_per_q <= act_per_d;
      act_db_q <= act_db_d;
      act_duty_q <= act_duty_d;
      pend_q <= pend_d;
    end
  end
  assign act_period = act_per_q;
  assign act_deadband = act_db_q;
  assign act_duty = act_duty_q;
  assign pending = pend_q;
endmodule

// File: rtl/motor_pwm_timebase.sv
// motor_pwm_timebase: shared PWM up-counter, zero sync and double-buffered settings; MOTOR_PWM_ADC_TRIG_EN adds oADC_TRIG
module motor_pwm_timebase
  import motor_pwm_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int PHASES = PHASES_DEF,
  parameter int RST_PERIOD = RST_PERIOD_DEF
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iENABLE,
  input  logic                   iLOAD,
  input  logic [SIZE-1:0]        iPERIOD,
  input  logic [SIZE-1:0]        iDEADBAND,
  input  logic [PHASES*SIZE-1:0] iDUTY,
  output logic                   oENABLE,
  output logic [SIZE-1:0]        oCOUNTER,
  output logic [SIZE-1:0]        oPERIOD,
  output logic [SIZE-1:0]        oDEADBAND,
  output logic [PHASES*SIZE-1:0] oDUTY,
  output logic                   oZERO,
  output logic                   oPENDING,
  output logic                   oUPDATED
`ifdef MOTOR_PWM_ADC_TRIG_EN
  ,
  output logic                   oADC_TRIG
`endif
);
  state_e state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic en_q, en_d, zero_q, zero_d, upd_q, upd_d;
  logic running, wrap, apply, applied;
  motor_pwm_shadow #(.SIZE(SIZE), .PHASES(PHASES), .RST_PERIOD(RST_PERIOD)) u_shadow (
    .clk(iCLK),
    .rst(iRST),
    .load(iLOAD),
    .apply(apply),
    .period(iPERIOD),
    .deadband(iDEADBAND),
    .duty(iDUTY),
    .act_period(oPERIOD),
    .act_deadband(oDEADBAND),
    .act_duty(oDUTY),
    .pending(oPENDING),
    .applied(applied)
  );
  always_comb begin
    running = state_q != IDLE;
    wrap = running && cnt_q == oPERIOD - SIZE'(1);
    apply = wrap || (!running && iENABLE);
    state_d = iENABLE ? RUN : (running && !wrap) ? DRAIN : IDLE;
    en_d = state_d != IDLE;
    cnt_d = (running && !wrap) ? cnt_q + SIZE'(1) : '0;
    zero_d = en_d && cnt_d == '0;
    upd_d = applied;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      en_q <= 1'b0;
      zero_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      zero_q <= zero_d;
      upd_q <= upd_d;
    end
  end
  assign oENABLE = en_q;
  assign oCOUNTER = cnt_q;
  assign oZERO = zero_q;
  assign oUPDATED = upd_q;
`ifdef MOTOR_PWM_ADC_TRIG_EN
  logic adc_q, adc_d;
  always_comb adc_d = en_d && cnt_d == (oPERIOD >> 1);
  always_ff @(posedge iCLK) begin
    if (iRST) adc_q <= 1'b0;
    else adc_q <= adc_d;
  end
  assign oADC_TRIG = adc_q;
`endif
endmodule

// File: tb/tb_motor_pwm_timebase.sv
// tb_motor_pwm_timebase: scoreboard bench for motor_pwm_timebase with hand-computed per-cycle expectations
module tb_motor_pwm_timebase;
  logic clk = 0, rst = 1, ien = 0, ild = 0;
  logic [15:0] iper = 0, idb = 0;
  logic [47:0] iduty = 0;
  logic oen, ozero, opend, oupd;
  logic [15:0] ocnt, oper, odb;
  logic [47:0] oduty;
`ifdef MOTOR_PWM_ADC_TRIG_EN
  logic oadc;
`endif
  int cyc = 0, tests = 0, fails = 0;
  typedef enum {S_CNT, S_EN, S_ZERO, S_PEND, S_UPD, S_PER, S_DB, S_DUTY, S_ADC} sel_e;
  typedef struct {string name; int cyc; sel_e sel; logic [47:0] val;} exp_t;
  exp_t sb[$];
  motor_pwm_timebase dut (
    .iCLK(clk),
    .iRST(rst),
    .iENABLE(ien),
    .iLOAD(ild),
    .iPERIOD(iper),
    .iDEADBAND(idb),
    .iDUTY(iduty),
    .oENABLE(oen),
    .oCOUNTER(ocnt),
    .oPERIOD(oper),
    .oDEADBAND(odb),
    .oDUTY(oduty),
    .oZERO(ozero),
    .oPENDING(opend),
    .oUPDATED(oupd)
`ifdef MOTOR_PWM_ADC_TRIG_EN
    ,
    .oADC_TRIG(oadc)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [47:0] act(sel_e s);
    case (s)
      S_CNT: return 48'(ocnt);
      S_EN: return 48'(oen);
      S_ZERO: return 48'(ozero);
      S_PEND: return 48'(opend);
      S_UPD: return 48'(oupd);
      S_PER: return 48'(oper);
      S_DB: return 48'(odb);
      S_DUTY: return oduty;
`ifdef MOTOR_PWM_ADC_TRIG_EN
      S_ADC: return 48'(oadc);
`endif
      default: return '1;
    endcase
  endfunction
  always @(negedge clk) begin
    logic [47:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        a = act(sb[i].sel);
        tests++;
        if (sb[i].cyc < cyc || a !== sb[i].val) begin
          fails++;
          $display("FAIL %s @cycle %0d: got %0d, expected %0d", sb[i].name, sb[i].cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end
  task automatic ex(input string n, input int c, input sel_e s, input logic [47:0] v);
    exp_t e;
    e.name = n;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic to_cyc(input int p);
    while (cyc < p) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic load(input logic [15:0] p, input logic [15:0] d, input logic [47:0] du);
    iper = p;
    idb = d;
    iduty = du;
    ild = 1;
    @(posedge clk);
    #2;
    ild = 0;
  endtask
  initial begin
    to_cyc(2);
    tests++;
    if (ocnt !== 16'd0 || oen !== 1'b0 || oper !== 16'd1000 || opend !== 1'b0 || oupd !== 1'b0 || ozero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d en=%0b per=%0d pend=%0b upd=%0b zero=%0b", ocnt, oen, oper, opend, oupd, ozero);
    end
    ex("rst_cnt", 2, S_CNT, 0); ex("rst_en", 2, S_EN, 0); ex("rst_per", 2, S_PER, 1000);
    ex("rst_pend", 2, S_PEND, 0); ex("rst_upd", 2, S_UPD, 0); ex("rst_zero", 2, S_ZERO, 0);
    ex("rst_db", 2, S_DB, 0); ex("rst_duty", 2, S_DUTY, 0);
    rst = 0;
    ien = 1;
    ex("start_en", 3, S_EN, 1); ex("start_cnt", 3, S_CNT, 0); ex("start_zero", 3, S_ZERO, 1);
    ex("cnt1", 4, S_CNT, 1); ex("zero_off", 4, S_ZERO, 0);
    ex("cnt999", 1002, S_CNT, 999); ex("zero_at_999", 1002, S_ZERO, 0);
    ex("wrap1000", 1003, S_CNT, 0); ex("zero1000", 1003, S_ZERO, 1); ex("cnt500", 1503, S_CNT, 500);
    to_cyc(1502);
    load(100, 0, 0);
    ex("pend_pre_rst", 1503, S_PEND, 1); ex("per_hold_pre_rst", 1503, S_PER, 1000);
    rst = 1;
    ien = 0;
    ex("midrst_cnt", 1504, S_CNT, 0); ex("midrst_en", 1504, S_EN, 0); ex("midrst_per", 1504, S_PER, 1000);
    ex("midrst_pend", 1504, S_PEND, 0); ex("midrst_zero", 1504, S_ZERO, 0);
    to_cyc(1504);
    rst = 0;
    load(100, 0, 0);
    ex("idle_pend", 1505, S_PEND, 1); ex("idle_per", 1505, S_PER, 1000); ex("idle_en", 1505, S_EN, 0);
    ien = 1;
    ex("go_per", 1506, S_PER, 100); ex("go_upd", 1506, S_UPD, 1); ex("go_pend", 1506, S_PEND, 0);
    ex("go_cnt", 1506, S_CNT, 0); ex("go_zero", 1506, S_ZERO, 1); ex("go_en", 1506, S_EN, 1);
    ex("go_upd_off", 1507, S_UPD, 0);
    to_cyc(1546);
    ex("cnt40", 1546, S_CNT, 40);
    load(50, 0, 48'd20);
    ex("p50_pend", 1547, S_PEND, 1); ex("p50_per_hold", 1547, S_PER, 100); ex("p50_cnt41", 1547, S_CNT, 41);
    ex("p100_cnt99", 1605, S_CNT, 99); ex("p100_per_end", 1605, S_PER, 100);
    ex("p50_wrap_cnt", 1606, S_CNT, 0); ex("p50_per", 1606, S_PER, 50); ex("p50_upd", 1606, S_UPD, 1);
    ex("p50_pend_clr", 1606, S_PEND, 0); ex("p50_duty", 1606, S_DUTY, 48'd20); ex("p50_zero", 1606, S_ZERO, 1);
    ex("p50_cnt49", 1655, S_CNT, 49); ex("p50_wrap2", 1656, S_CNT, 0); ex("p50_zero2", 1656, S_ZERO, 1);
    ex("p50_upd_once", 1656, S_UPD, 0);
    to_cyc(1660);
    load(200, 50, 48'h0000_012C_0000);
    ex("clamp_pend", 1661, S_PEND, 1); ex("clamp_cnt49", 1705, S_CNT, 49); ex("clamp_per_hold", 1705, S_PER, 50);
    ex("clamp_per", 1706, S_PER, 200); ex("clamp_duty1", 1706, S_DUTY, 48'h0000_00C8_0000);
    ex("clamp_db", 1706, S_DB, 0); ex("clamp_upd", 1706, S_UPD, 1); ex("clamp_cnt0", 1706, S_CNT, 0);
    to_cyc(1710);
    load(1, 0, 0);
    ex("p200_cnt199", 1905, S_CNT, 199); ex("min_per", 1906, S_PER, 2); ex("min_cnt0", 1906, S_CNT, 0);
    ex("min_duty", 1906, S_DUTY, 0); ex("min_cnt1", 1907, S_CNT, 1); ex("min_zero_off", 1907, S_ZERO, 0);
    ex("min_wrap", 1908, S_CNT, 0); ex("min_zero", 1908, S_ZERO, 1);
    to_cyc(1908);
    load(100, 0, 0);
    ex("min2_cnt1", 1909, S_CNT, 1); ex("min2_pend", 1909, S_PEND, 1); ex("min2_per_hold", 1909, S_PER, 2);
    ex("p100b_cnt0", 1910, S_CNT, 0); ex("p100b_per", 1910, S_PER, 100); ex("p100b_upd", 1910, S_UPD, 1);
`ifdef MOTOR_PWM_ADC_TRIG_EN
    ex("adc_49", 1959, S_ADC, 0); ex("adc_50", 1960, S_ADC, 1); ex("adc_51", 1961, S_ADC, 0);
`endif
    to_cyc(1940);
    ien = 0;
    ex("drain_cnt31", 1941, S_CNT, 31); ex("drain_en", 1941, S_EN, 1);
    ex("drain_cnt99", 2009, S_CNT, 99); ex("drain_en99", 2009, S_EN, 1);
    ex("drain_wrap_cnt", 2010, S_CNT, 0); ex("drain_wrap_en", 2010, S_EN, 0); ex("drain_wrap_zero", 2010, S_ZERO, 0);
    ex("idle_hold_cnt", 2011, S_CNT, 0); ex("idle_hold_en", 2011, S_EN, 0);
    to_cyc(2011);
    ien = 1;
    ex("rerun_cnt", 2012, S_CNT, 0); ex("rerun_en", 2012, S_EN, 1); ex("rerun_zero", 2012, S_ZERO, 1);
    ex("redrain_cnt48", 2060, S_CNT, 48);
    to_cyc(2042);
    ien = 0;
    to_cyc(2072);
    ien = 1;
    ex("resume_cnt61", 2073, S_CNT, 61); ex("resume_en", 2073, S_EN, 1); ex("resume_cnt99", 2111, S_CNT, 99);
    ex("resume_wrap", 2112, S_CNT, 0); ex("resume_wrap_en", 2112, S_EN, 1); ex("resume_zero", 2112, S_ZERO, 1);
    to_cyc(2211);
    load(60, 0, 0);
    ex("coinc_cnt0", 2212, S_CNT, 0); ex("coinc_upd", 2212, S_UPD, 0); ex("coinc_pend", 2212, S_PEND, 1);
    ex("coinc_per", 2212, S_PER, 100); ex("coinc_cnt99", 2311, S_CNT, 99);
    ex("coinc_apply_cnt", 2312, S_CNT, 0); ex("coinc_apply_per", 2312, S_PER, 60);
    ex("coinc_apply_upd", 2312, S_UPD, 1); ex("coinc_apply_pend", 2312, S_PEND, 0);
    ex("coinc_upd_off", 2313, S_UPD, 0); ex("p60_cnt59", 2371, S_CNT, 59);
    ex("p60_wrap", 2372, S_CNT, 0); ex("p60_zero", 2372, S_ZERO, 1);
    to_cyc(2380);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL expired_wait: %0d expectations never checked", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
